// File: rtl/bcd_counter_n_if.sv
// rtl/bcd_counter_n_if.sv - control and display bus of the N-digit BCD counter
interface bcd_counter_n_if #(
  parameter int DIGITS = 4
);
  logic                  run;
  logic                  src;
  logic                  inc;
  logic                  down;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   q;
  logic                  tick;
  logic                  carry;
  logic                  at_zero;
  logic                  at_max;

  modport master (
    output run, src, inc, down, clear, load, load_val,
    input  q, tick, carry, at_zero, at_max
  );

  modport slave (
    input  run, src, inc, down, clear, load, load_val,
    output q, tick, carry, at_zero, at_max
  );
endinterface

// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - N-digit BCD up/down counter with prescaler, wrap or saturate
module bcd_counter_n #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 10_000_000,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  bcd_counter_n_if.slave   bus
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0]          pre;
  logic [4*DIGITS-1:0]    q_r;
  logic                   carry_r;
  logic [4*DIGITS-1:0]    stepped;
  logic [4*DIGITS-1:0]    clamped;
  logic                   ripple;
  logic                   all_nine;
  logic                   pre_last;
  logic                   step;
  logic                   limit;

  assign pre_last = (pre == PRE_MAX);
  assign step     = bus.run & (bus.src ? bus.inc : pre_last);
  assign limit    = bus.down ? bus.at_zero : bus.at_max;

  assign bus.q       = q_r;
  assign bus.carry   = carry_r;
  assign bus.tick    = bus.run & ~bus.src & pre_last;
  assign bus.at_zero = (q_r == '0);
  assign bus.at_max  = all_nine;

  // Ripple one step through the digits; a full wrap falls out naturally (9..9 -> 0..0 and back).
  always_comb begin
    stepped  = q_r;
    clamped  = bus.load_val;
    ripple   = 1'b1;
    all_nine = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (q_r[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (bus.load_val[4*i +: 4] > 4'd9) clamped[4*i +: 4] = 4'd9;
      if (ripple) begin
        if (!bus.down) begin
          if (q_r[4*i +: 4] == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = q_r[4*i +: 4] + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (q_r[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = q_r[4*i +: 4] - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre     <= '0;
      q_r     <= '0;
      carry_r <= 1'b0;
    end else begin
      if (bus.clear || bus.src) pre <= '0;
      else if (bus.run)         pre <= pre_last ? '0 : pre + 1'b1;

      if (bus.clear) begin
        q_r     <= '0;
        carry_r <= 1'b0;
      end else if (bus.load) begin
        q_r     <= clamped;
        carry_r <= 1'b0;
      end else if (step) begin
        carry_r <= limit;
        // Saturating variant refuses to leave the range limit.
        if (!(limit && SATURATE != 0)) q_r <= stepped;
      end else begin
        carry_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - checks wrap and saturate instances against an integer model
module tb_bcd_counter_n;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int MAXV   = 9999;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int   mv [2];
  bit   mc [2];
  int   mpre;

  bcd_counter_n_if #(.DIGITS(DIGITS)) b0 ();
  bcd_counter_n_if #(.DIGITS(DIGITS)) b1 ();

  assign b1.run      = b0.run;
  assign b1.src      = b0.src;
  assign b1.inc      = b0.inc;
  assign b1.down     = b0.down;
  assign b1.clear    = b0.clear;
  assign b1.load     = b0.load;
  assign b1.load_val = b0.load_val;

  bcd_counter_n #(.DIGITS(DIGITS), .DIV(DIV), .SATURATE(0)) dut_wrap (.clk(clk), .reset(reset), .bus(b0));
  bcd_counter_n #(.DIGITS(DIGITS), .DIV(DIV), .SATURATE(1)) dut_sat  (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v, mul, d;
    v = 0;
    mul = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * mul;
      mul = mul * 10;
    end
    return v;
  endfunction

  function automatic bit exp_tick();
    return b0.run && !b0.src && (mpre == DIV - 1);
  endfunction

  task automatic model_reset();
    mv[0] = 0; mv[1] = 0; mc[0] = 0; mc[1] = 0; mpre = 0;
  endtask

  // Advance the integer model with the inputs present before the edge, then take the edge.
  task automatic cycle();
    bit stp;
    stp = b0.run && (b0.src ? b0.inc : (mpre == DIV - 1));
    for (int s = 0; s < 2; s++) begin
      if (b0.clear) begin
        mv[s] = 0; mc[s] = 0;
      end else if (b0.load) begin
        mv[s] = from_load(b0.load_val); mc[s] = 0;
      end else if (stp && !b0.down) begin
        if (mv[s] == MAXV) begin mc[s] = 1; if (s == 0) mv[s] = 0; end
        else begin mv[s] = mv[s] + 1; mc[s] = 0; end
      end else if (stp && b0.down) begin
        if (mv[s] == 0) begin mc[s] = 1; if (s == 0) mv[s] = MAXV; end
        else begin mv[s] = mv[s] - 1; mc[s] = 0; end
      end else begin
        mc[s] = 0;
      end
    end
    if (b0.clear || b0.src) mpre = 0;
    else if (b0.run)        mpre = (mpre + 1) % DIV;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit run, input bit src, input bit inc, input bit down,
                        input bit clear, input bit load, input logic [15:0] lv);
    b0.run = run; b0.src = src; b0.inc = inc; b0.down = down;
    b0.clear = clear; b0.load = load; b0.load_val = lv;
    #1;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0, 16'h0);
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (b0.q !== 16'h0000) begin failures++; $display("FAIL reset_q got=%h exp=0000", b0.q); end
    checks++; if (b0.carry !== 1'b0 || b1.carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b%b exp=00", b0.carry, b1.carry); end
    checks++; if (b0.at_zero !== 1'b1 || b0.at_max !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=10", b0.at_zero, b0.at_max); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_prescaler();
    set_in(1, 0, 0, 0, 0, 0, 16'h0);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      checks++;
      if (b0.q !== to_bcd(k / 4)) begin failures++; $display("FAIL presc_q edge=%0d got=%h exp=%h", k, b0.q, to_bcd(k / 4)); end
      checks++;
      if (b0.tick !== (k % 4 == 3)) begin failures++; $display("FAIL presc_tick edge=%0d got=%b exp=%b", k, b0.tick, (k % 4 == 3)); end
    end
  endtask

  task automatic test_ext_up();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0999; exp_seq[1] = 16'h1000; exp_seq[2] = 16'h1001;
    set_in(1, 1, 0, 0, 0, 1, 16'h0998); cycle();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 1, 0, 0, 0, 16'h0); cycle();
      checks++;
      if (b0.q !== exp_seq[k] || b1.q !== exp_seq[k]) begin failures++; $display("FAIL ext_up k=%0d got=%h/%h exp=%h", k, b0.q, b1.q, exp_seq[k]); end
    end
    set_in(1, 1, 0, 0, 0, 1, 16'h9999); cycle();
    set_in(1, 1, 1, 0, 0, 0, 16'h0); cycle();
    checks++; if (b0.q !== 16'h0000 || b0.carry !== 1'b1 || b0.at_zero !== 1'b1) begin failures++; $display("FAIL wrap_up got=%h c=%b z=%b exp=0000 c=1 z=1", b0.q, b0.carry, b0.at_zero); end
    checks++; if (b1.q !== 16'h9999 || b1.carry !== 1'b1) begin failures++; $display("FAIL sat_up got=%h c=%b exp=9999 c=1", b1.q, b1.carry); end
    cycle();
    checks++; if (b1.q !== 16'h9999 || b1.carry !== 1'b1) begin failures++; $display("FAIL sat_up2 got=%h c=%b exp=9999 c=1", b1.q, b1.carry); end
    checks++; if (b0.q !== 16'h0001 || b0.carry !== 1'b0) begin failures++; $display("FAIL wrap_after got=%h c=%b exp=0001 c=0", b0.q, b0.carry); end
    set_in(1, 1, 0, 0, 0, 0, 16'h0); cycle();
    checks++; if (b1.carry !== 1'b0) begin failures++; $display("FAIL carry_pulse got=%b exp=0", b1.carry); end
  endtask

  task automatic test_down();
    set_in(1, 1, 0, 1, 0, 1, 16'h0100); cycle();
    set_in(1, 1, 1, 1, 0, 0, 16'h0); cycle();
    checks++; if (b0.q !== 16'h0099) begin failures++; $display("FAIL down_borrow got=%h exp=0099", b0.q); end
    set_in(1, 1, 0, 1, 0, 1, 16'h0000); cycle();
    set_in(1, 1, 1, 1, 0, 0, 16'h0); cycle();
    checks++; if (b0.q !== 16'h9999 || b0.carry !== 1'b1) begin failures++; $display("FAIL down_wrap got=%h c=%b exp=9999 c=1", b0.q, b0.carry); end
    checks++; if (b1.q !== 16'h0000 || b1.carry !== 1'b1) begin failures++; $display("FAIL down_sat got=%h c=%b exp=0000 c=1", b1.q, b1.carry); end
  endtask

  task automatic test_priority();
    set_in(1, 1, 1, 0, 0, 1, 16'hC3F5); cycle();
    checks++; if (b0.q !== 16'h9395 || b0.carry !== 1'b0) begin failures++; $display("FAIL load_clamp got=%h c=%b exp=9395 c=0", b0.q, b0.carry); end
    set_in(1, 1, 1, 0, 1, 1, 16'h1234); cycle();
    checks++; if (b0.q !== 16'h0000 || b0.carry !== 1'b0) begin failures++; $display("FAIL clear_wins got=%h c=%b exp=0000 c=0", b0.q, b0.carry); end
    set_in(1, 1, 0, 0, 0, 1, 16'h0042); cycle();
    set_in(0, 1, 1, 0, 0, 0, 16'h0); cycle(); cycle();
    checks++; if (b0.q !== 16'h0042) begin failures++; $display("FAIL run_gate got=%h exp=0042", b0.q); end
  endtask

  task automatic test_back_to_back();
    set_in(1, 1, 0, 0, 1, 0, 16'h0); cycle();
    set_in(1, 1, 1, 0, 0, 0, 16'h0);
    for (int k = 0; k < 5; k++) cycle();
    set_in(1, 1, 0, 0, 0, 0, 16'h0); cycle(); cycle();
    checks++; if (b0.q !== 16'h0005) begin failures++; $display("FAIL inc_held got=%h exp=0005", b0.q); end
  endtask

  task automatic test_async_reset();
    int k;
    set_in(1, 0, 0, 0, 1, 0, 16'h0); cycle();
    set_in(1, 0, 0, 0, 0, 1, 16'h0042); cycle();
    set_in(1, 0, 0, 0, 0, 0, 16'h0); cycle();
    checks++; if (b0.q !== 16'h0042 || mpre != 2) begin failures++; $display("FAIL pre_setup got=%h exp=0042", b0.q); end
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (b0.q !== 16'h0000 || b1.q !== 16'h0000 || b0.carry !== 1'b0 || b0.tick !== 1'b0) begin failures++; $display("FAIL async_reset got=%h/%h c=%b t=%b exp=0000 c=0 t=0", b0.q, b1.q, b0.carry, b0.tick); end
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    while (k < 12 && b0.q === 16'h0000) begin
      cycle();
      k++;
    end
    checks++; if (k != DIV || b0.q !== 16'h0001) begin failures++; $display("FAIL first_tick got_edges=%0d q=%h exp_edges=%0d q=0001", k, b0.q, DIV); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0,
             16'($urandom));
      if (n % 50 == 0) begin b0.load = 1'b1; b0.load_val = (n % 100 == 0) ? 16'h9999 : 16'h0000; #1; end
      checks++;
      if (b0.tick !== exp_tick()) begin failures++; $display("FAIL rnd_tick n=%0d got=%b exp=%b", n, b0.tick, exp_tick()); end
      cycle();
      checks++;
      if (b0.q !== to_bcd(mv[0]) || b0.carry !== mc[0]) begin failures++; $display("FAIL rnd_wrap n=%0d got=%h c=%b exp=%h c=%b", n, b0.q, b0.carry, to_bcd(mv[0]), mc[0]); end
      checks++;
      if (b1.q !== to_bcd(mv[1]) || b1.carry !== mc[1]) begin failures++; $display("FAIL rnd_sat n=%0d got=%h c=%b exp=%h c=%b", n, b1.q, b1.carry, to_bcd(mv[1]), mc[1]); end
      checks++;
      if (b0.at_zero !== (mv[0] == 0) || b0.at_max !== (mv[0] == MAXV)) begin failures++; $display("FAIL rnd_flags n=%0d got=%b%b exp=%b%b", n, b0.at_zero, b0.at_max, mv[0] == 0, mv[0] == MAXV); end
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_ext_up();
    test_down();
    test_priority();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
